qed_encoder: RTL and testbench
==============================

QED_ENCODER -- requirements
Module: qed_encoder

Interface
REQ-001 The block SHALL have parameter MEM_OFFSET, default 12'h400: the 12-bit offset added to the LW/SW immediate in duplicate instructions.
REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- qed_ena  in  1  duplication enable, sampled on input acceptance.
- in_valid  in  1  decoded-instruction fields valid.
- in_ready  out  1  block can accept fields this cycle.
- opcode  in  7  decoded opcode.
- rd  in  5  decoded destination register.
- rs1  in  5  decoded source register 1.
- rs2  in  5  decoded source register 2.
- funct3  in  3  decoded funct3.
- funct7  in  7  decoded funct7; also the S-type imm[11:5].
- imm12  in  12  decoded I-type immediate.
- imm5  in  5  decoded S-type imm[4:0].
- uimm31  in  20  decoded U-type immediate.
- out_valid  out  1  out_instr valid.
- out_ready  in  1  consumer accepts out_instr.
- out_instr  out  32  re-encoded instruction word.
- out_is_dup  out  1  out_instr is the duplicate copy.
- dup_count  out  16  saturating count of duplicates emitted.

Function
REQ-003 The original word SHALL be rebuilt by opcode:
- R (0110011): funct7|rs2|rs1|funct3|rd|opcode.
- I (0010011) and LW (0000011): imm12|rs1|funct3|rd|opcode.
- SW (0100011): funct7|rs2|rs1|funct3|imm5|opcode.
- LUI (0110111) and AUIPC (0010111): uimm31|rd|opcode.
- All other opcodes: the fields are re-encoded in R layout.
REQ-004 Register remap SHALL be r' = {1'b1, r[3:0]} for r != 0; x0 SHALL stay x0.
REQ-005 The duplicate word for R, I, LUI and AUIPC SHALL be the original word with rd, rs1 and rs2 remapped (only the fields present in that format).
REQ-006 The duplicate word for LW SHALL have rd and rs1 remapped and immediate = (imm12 + MEM_OFFSET) mod 2^12.
REQ-007 The duplicate word for SW SHALL have rs1 and rs2 remapped and its 12-bit immediate {funct7, imm5} = ({funct7, imm5} + MEM_OFFSET) mod 2^12, with the result split back into the two fields.
REQ-008 The duplicate word for branch, JAL, JALR and all unlisted opcodes SHALL be NOP 32'h00000013.
REQ-009 The FSM SHALL have three states:
- EMPTY: out_valid=0.
- ORIG: out_valid=1, out_instr=original word, out_is_dup=0.
- DUP: out_valid=1, out_instr=duplicate word, out_is_dup=1.
REQ-010 An input SHALL be accepted when in_valid and in_ready are both high. On acceptance the block SHALL register the original word, the duplicate word and dup_pending=qed_ena, then enter ORIG the next cycle (latency 1).
REQ-011 In ORIG with out_ready=1, the FSM SHALL go to DUP if dup_pending=1; otherwise it SHALL go to ORIG if an input is accepted the same cycle, else to EMPTY.
REQ-012 In DUP with out_ready=1, the FSM SHALL go to ORIG if an input is accepted the same cycle, else to EMPTY, and dup_count SHALL increment.
REQ-013 in_ready SHALL be (state==EMPTY) | (state==ORIG & !dup_pending & out_ready) | (state==DUP & out_ready), combinational from out_ready.
REQ-014 While out_valid=1 and out_ready=0, out_instr and out_is_dup SHALL hold stable.
REQ-015 A change of qed_ena after acceptance SHALL NOT affect the instruction already accepted.
REQ-016 dup_count SHALL saturate at 16'hFFFF and never wrap.
REQ-017 With qed_ena=0 the block SHALL sustain one instruction per cycle; with qed_ena=1 it SHALL sustain one instruction per two cycles.

Reset
REQ-018 When rst_n=0 at a clock edge, the block SHALL set state=EMPTY, out_valid=0, out_instr=0, out_is_dup=0, dup_pending=0 and dup_count=0.
REQ-019 Reset asserted in ORIG or DUP SHALL discard the pending original or duplicate word, and in_ready SHALL be 1 on the first cycle after rst_n rises.

Verification
REQ-020 The bench SHALL cover these scenarios:
- qed_ena=1, add x1,x2,x3 (funct7=0, rs2=3, rs1=2, f3=0, rd=1, op=0110011), out_ready=1 -> 0x003100B3 (dup=0), then 0x013908B3 (dup=1), dup_count=1.
- qed_ena=1, LW x5,8(x6), MEM_OFFSET=12'h400 -> 0x00832283, then 0x408B2A83.
- qed_ena=1, addi x0,x0,0 -> 0x00000013 twice; a BEQ input -> the original word, then 0x00000013.
- qed_ena=0, four back-to-back R instructions, out_ready=1 -> four originals on consecutive cycles, no dup beats, in_ready stays 1.
- out_ready=0 for 5 cycles while in ORIG -> out_instr stable and in_ready=0; qed_ena toggled meanwhile -> the duplicate is still emitted.
- rst_n=0 during DUP -> next cycle out_valid=0, dup_count=0, in_ready=1, and no duplicate is emitted.

Source files
------------

// File: rtl/qed_encoder.sv
// qed_encoder
// Rebuilds a 32-bit RV32I instruction word from decoded fields and, when QED
// duplication is enabled, follows it with a duplicate copy. The duplicate uses
// the upper register bank (x16..x31) and data memory shifted by MEM_OFFSET.
//
// Ports
//   clk        : sole clock, rising edge
//   rst_n      : synchronous active-low reset
//   qed_ena    : duplication enable, captured when an input is accepted
//   in_valid   : decoded fields valid          in_ready : can accept this cycle
//   opcode, rd, rs1, rs2, funct3, funct7, imm12, imm5, uimm31 : decoded fields
//   out_valid  : out_instr valid               out_ready : consumer accepts
//   out_instr  : re-encoded instruction word
//   out_is_dup : out_instr is the duplicate copy
//   dup_count  : saturating count of duplicates emitted
module qed_encoder #(
  parameter logic [11:0] MEM_OFFSET = 12'h400
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        qed_ena,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [11:0] imm12,
  input  logic [4:0]  imm5,
  input  logic [19:0] uimm31,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_is_dup,
  output logic [15:0] dup_count
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [31:0] NOP     = 32'h00000013;

  typedef enum logic [1:0] {EMPTY, ORIG, DUP} state_t;

  state_t      state;
  logic        dup_pending;
  logic [31:0] dup_word_q;
  logic [31:0] orig_word;
  logic [31:0] dup_word;
  logic [11:0] lw_imm;
  logic [11:0] sw_imm;
  logic        accept;

  // Upper-bank remap; x0 stays x0 so hard-wired zero semantics are preserved.
  function automatic logic [4:0] remap(input logic [4:0] r);
    return (r == 5'd0) ? 5'd0 : {1'b1, r[3:0]};
  endfunction

  assign lw_imm = imm12 + MEM_OFFSET;
  assign sw_imm = {funct7, imm5} + MEM_OFFSET;

  always_comb begin
    orig_word = {funct7, rs2, rs1, funct3, rd, opcode};
    dup_word  = NOP;
    case (opcode)
      OP_R: begin
        orig_word = {funct7, rs2, rs1, funct3, rd, opcode};
        dup_word  = {funct7, remap(rs2), remap(rs1), funct3, remap(rd), opcode};
      end
      OP_I: begin
        orig_word = {imm12, rs1, funct3, rd, opcode};
        dup_word  = {imm12, remap(rs1), funct3, remap(rd), opcode};
      end
      OP_LW: begin
        orig_word = {imm12, rs1, funct3, rd, opcode};
        dup_word  = {lw_imm, remap(rs1), funct3, remap(rd), opcode};
      end
      OP_SW: begin
        orig_word = {funct7, rs2, rs1, funct3, imm5, opcode};
        dup_word  = {sw_imm[11:5], remap(rs2), remap(rs1), funct3, sw_imm[4:0], opcode};
      end
      OP_LUI, OP_AUIPC: begin
        orig_word = {uimm31, rd, opcode};
        dup_word  = {uimm31, remap(rd), opcode};
      end
      default: begin
        orig_word = {funct7, rs2, rs1, funct3, rd, opcode};
        dup_word  = NOP;
      end
    endcase
  end

  assign in_ready = (state == EMPTY)
                  | ((state == ORIG) & ~dup_pending & out_ready)
                  | ((state == DUP) & out_ready);
  assign accept   = in_valid & in_ready;

  // in_ready is low in ORIG while a duplicate is pending, so acceptance never
  // coincides with the ORIG->DUP step and can be handled first for all states.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= EMPTY;
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_is_dup  <= 1'b0;
      dup_pending <= 1'b0;
      dup_word_q  <= '0;
      dup_count   <= '0;
    end else begin
      if (state == DUP && out_ready && dup_count != 16'hFFFF)
        dup_count <= dup_count + 16'd1;

      if (accept) begin
        state       <= ORIG;
        out_valid   <= 1'b1;
        out_instr   <= orig_word;
        out_is_dup  <= 1'b0;
        dup_word_q  <= dup_word;
        dup_pending <= qed_ena;
      end else begin
        case (state)
          ORIG: begin
            if (out_ready) begin
              if (dup_pending) begin
                state      <= DUP;
                out_instr  <= dup_word_q;
                out_is_dup <= 1'b1;
              end else begin
                state      <= EMPTY;
                out_valid  <= 1'b0;
                out_is_dup <= 1'b0;
              end
            end
          end
          DUP: begin
            if (out_ready) begin
              state      <= EMPTY;
              out_valid  <= 1'b0;
              out_is_dup <= 1'b0;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qed_encoder.sv
// Testbench for qed_encoder: table of instruction vectors with hand-computed
// original and duplicate words, a scoreboard queue of expected output beats,
// and directed sequences for throughput, back-pressure and reset corners.
module tb_qed_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        qed_ena = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [11:0] imm12 = '0;
  logic [4:0]  imm5 = '0;
  logic [19:0] uimm31 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic        out_is_dup;
  logic [15:0] dup_count;

  qed_encoder #(.MEM_OFFSET(12'h400)) dut (
    .clk(clk), .rst_n(rst_n), .qed_ena(qed_ena),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm12(imm12), .imm5(imm5),
    .uimm31(uimm31),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_is_dup(out_is_dup), .dup_count(dup_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [6:0]  f7;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [11:0] imm12;
    logic [4:0]  imm5;
    logic [19:0] uimm;
    logic        ena;
    logic [31:0] eo;
    logic [31:0] ed;
  } vec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        dup;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   exp_dups = 0;
  vec_t vecs[12];

  function automatic vec_t mk(input logic [6:0] op, input logic [6:0] f7,
                              input logic [4:0] rs2_v, input logic [4:0] rs1_v,
                              input logic [2:0] f3, input logic [4:0] rd_v,
                              input logic [11:0] i12, input logic [4:0] i5,
                              input logic [19:0] u, input logic ena,
                              input logic [31:0] eo, input logic [31:0] ed);
    vec_t v;
    v.op = op; v.f7 = f7; v.rs2 = rs2_v; v.rs1 = rs1_v; v.f3 = f3; v.rd = rd_v;
    v.imm12 = i12; v.imm5 = i5; v.uimm = u; v.ena = ena; v.eo = eo; v.ed = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Output monitor: every accepted beat is popped from the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_output: got %08h dup=%0b expected no beat", out_instr, out_is_dup);
      end else begin
        e = sb.pop_front();
        check("out_instr", out_instr, e.instr);
        check("out_is_dup", {31'b0, out_is_dup}, {31'b0, e.dup});
      end
    end
  end

  // Drive one instruction until accepted; waited = cycles in_ready was low.
  task automatic send(input vec_t v, output int waited);
    int n;
    n = 0;
    in_valid = 1'b1;
    opcode = v.op; funct7 = v.f7; rs2 = v.rs2; rs1 = v.rs1; funct3 = v.f3;
    rd = v.rd; imm12 = v.imm12; imm5 = v.imm5; uimm31 = v.uimm; qed_ena = v.ena;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        vectors++;
        miscompares++;
        $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        in_valid = 1'b0;
        waited = n;
        return;
      end
    end
    sb.push_back({v.eo, 1'b0});
    if (v.ena) begin
      sb.push_back({v.ed, 1'b1});
      exp_dups++;
    end
    waited = n;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int w;
    vecs[0]  = mk(7'h33, 7'h00, 5'd3,  5'd2,  3'd0, 5'd1,  12'h000, 5'd0,  20'h00000, 1'b1, 32'h003100B3, 32'h013908B3);
    vecs[1]  = mk(7'h03, 7'h00, 5'd0,  5'd6,  3'd2, 5'd5,  12'h008, 5'd0,  20'h00000, 1'b1, 32'h00832283, 32'h408B2A83);
    vecs[2]  = mk(7'h13, 7'h00, 5'd0,  5'd0,  3'd0, 5'd0,  12'h000, 5'd0,  20'h00000, 1'b1, 32'h00000013, 32'h00000013);
    vecs[3]  = mk(7'h63, 7'h00, 5'd2,  5'd1,  3'd0, 5'd8,  12'h000, 5'd0,  20'h00000, 1'b1, 32'h00208463, 32'h00000013);
    vecs[4]  = mk(7'h23, 7'h00, 5'd7,  5'd9,  3'd2, 5'd3,  12'h000, 5'd20, 20'h00000, 1'b1, 32'h0074AA23, 32'h417CAA23);
    vecs[5]  = mk(7'h23, 7'h60, 5'd0,  5'd16, 3'd2, 5'd0,  12'h000, 5'h10, 20'h00000, 1'b1, 32'hC0082823, 32'h00082823);
    vecs[6]  = mk(7'h37, 7'h00, 5'd0,  5'd0,  3'd0, 5'd10, 12'h000, 5'd0,  20'h12345, 1'b1, 32'h12345537, 32'h12345D37);
    vecs[7]  = mk(7'h17, 7'h00, 5'd0,  5'd0,  3'd0, 5'd31, 12'h000, 5'd0,  20'hFFFFF, 1'b1, 32'hFFFFFF97, 32'hFFFFFF97);
    vecs[8]  = mk(7'h6F, 7'h12, 5'd3,  5'd4,  3'd1, 5'd1,  12'h000, 5'd0,  20'h00000, 1'b1, 32'h243210EF, 32'h00000013);
    vecs[9]  = mk(7'h13, 7'h00, 5'd0,  5'd8,  3'd0, 5'd15, 12'hFFF, 5'd0,  20'h00000, 1'b1, 32'hFFF40793, 32'hFFFC0F93);
    vecs[10] = mk(7'h33, 7'h20, 5'd19, 5'd18, 3'd0, 5'd17, 12'h000, 5'd0,  20'h00000, 1'b0, 32'h413908B3, 32'h00000000);
    vecs[11] = mk(7'h03, 7'h00, 5'd0,  5'd0,  3'd2, 5'd0,  12'hC00, 5'd0,  20'h00000, 1'b1, 32'hC0002003, 32'h00002003);

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_is_dup", {31'b0, out_is_dup}, 32'd0);
    check("rst_dup_count", {16'b0, dup_count}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Table of single instructions, each drained and dup_count tracked
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      send(vecs[i], w);
      drain();
      check("dup_count", {16'b0, dup_count}, exp_dups);
    end

    // qed_ena=0: four back-to-back R instructions, one per cycle
    for (int i = 0; i < 4; i++) begin
      vec_t v;
      v = mk(7'h33, 7'h00, 5'(i + 1), 5'(i + 2), 3'd0, 5'(i + 3), 12'h000, 5'd0, 20'h0, 1'b0,
             {7'h00, 5'(i + 1), 5'(i + 2), 3'd0, 5'(i + 3), 7'h33}, 32'h0);
      send(v, w);
      check("b2b_in_ready_wait", w, 0);
    end
    drain();
    check("b2b_dup_count", {16'b0, dup_count}, exp_dups);

    // qed_ena=1 sustains one instruction per two cycles
    send(vecs[0], w);
    send(vecs[1], w);
    check("dup_rate_wait", w, 1);
    drain();

    // Back-pressure in ORIG with qed_ena toggling after acceptance
    out_ready = 1'b0;
    send(vecs[6], w);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_out_valid", {31'b0, out_valid}, 32'd1);
      check("stall_out_instr", out_instr, 32'h12345537);
      check("stall_out_is_dup", {31'b0, out_is_dup}, 32'd0);
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      qed_ena = ~qed_ena;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    check("stall_dup_count", {16'b0, dup_count}, exp_dups);

    // Reset while the duplicate is on the output
    send(vecs[0], w);
    @(posedge clk);
    #1;
    check("pre_rst_is_dup", {31'b0, out_is_dup}, 32'd1);
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("post_rst_dup_count", {16'b0, dup_count}, 32'd0);
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_dup", {31'b0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
